// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable / divided-clock generator with runtime glitch-free divisor updates
// and a lock indicator that re-arms on reset or sync_req.
module clk_div_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              sync_req,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [0:0] {StLocking, StRun} state_e;

    state_e              state_q, state_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                locked_q, locked_d;
    logic [DIV_W-1:0]    cnt_q [NUM_CH];
    logic [DIV_W-1:0]    cnt_d [NUM_CH];
    logic [DIV_W-1:0]    div_q [NUM_CH];
    logic [DIV_W-1:0]    div_d [NUM_CH];
    logic [DIV_W-1:0]    pval_q [NUM_CH];
    logic [DIV_W-1:0]    pval_d [NUM_CH];
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   ce_q, ce_d;
    logic [NUM_CH-1:0]   clk_q, clk_d;

    logic [NUM_CH-1:0]   enabled;
    logic [NUM_CH-1:0]   wrap;
    logic [NUM_CH-1:0]   high;
    logic [NUM_CH-1:0]   hit;
    logic [DIV_W:0]      half [NUM_CH];
    logic                running;

    // Writes to channels beyond NUM_CH see ready=1 and match no channel, so they are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == 4'(i)) begin
                cfg_ready = ~pend_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            enabled[i] = (div_q[i] != '0);
            wrap[i]    = enabled[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            half[i]    = ({1'b0, div_q[i]} + 1'b1) >> 1;
            high[i]    = ({1'b0, cnt_q[i]} < half[i]);
            hit[i]     = cfg_valid && cfg_ready && (cfg_ch == 4'(i));
        end
    end

    assign running = (state_q == StRun) && !sync_req;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        unique case (state_q)
            StLocking: begin
                if (sync_req) begin
                    lock_d = '0;
                end else if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                    lock_d  = '0;
                    state_d = StRun;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            StRun: begin
                if (sync_req) begin
                    lock_d  = '0;
                    state_d = StLocking;
                end
            end
            default: state_d = StLocking;
        endcase
        locked_d = (state_d == StRun);
    end

    always_comb begin
        pend_d = pend_q;
        ce_d   = '0;
        clk_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            pval_d[i] = pval_q[i];
            cnt_d[i]  = '0;
            if (running) begin
                if (enabled[i]) begin
                    ce_d[i]  = wrap[i];
                    clk_d[i] = high[i];
                    cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
                end
                if (pend_q[i] && wrap[i]) begin
                    div_d[i]  = pval_q[i];
                    pend_d[i] = 1'b0;
                end
                // A write landing on the wrap edge loads at once; the next period is new anyway.
                if (hit[i]) begin
                    if (!enabled[i] || wrap[i]) begin
                        div_d[i] = cfg_div;
                    end else begin
                        pend_d[i] = 1'b1;
                        pval_d[i] = cfg_div;
                    end
                end
            end else begin
                if (pend_q[i]) begin
                    div_d[i]  = pval_q[i];
                    pend_d[i] = 1'b0;
                end
                if (hit[i]) begin
                    div_d[i] = cfg_div;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= StLocking;
            lock_q   <= '0;
            locked_q <= 1'b0;
            pend_q   <= '0;
            ce_q     <= '0;
            clk_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DIV_INIT[i*DIV_W +: DIV_W];
                pval_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
            pend_q   <= pend_d;
            ce_q     <= ce_d;
            clk_q    <= clk_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pval_q[i] <= pval_d[i];
            end
        end
    end

    assign ce_out  = ce_q;
    assign clk_out = clk_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: lock timing, divider patterns, reconfiguration, sync, reset.
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       sync_req = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_ch = 4'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic [3:0] ce_out;
    logic [3:0] clk_out;
    logic       locked;

    int n_total = 0;
    int n_bad   = 0;
    int c       = 0;
    int n_e  [4];
    int st_e [4];
    logic lock_e;

    clk_div_bank #(
        .NUM_CH      (4),
        .DIV_W       (8),
        .DIV_INIT    ({8'd4, 8'd3, 8'd2, 8'd1}),
        .LOCK_CYCLES (16)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .sync_req  (sync_req),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .ce_out    (ce_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (c=%0d): got %0h want %0h", tag, c, got, exp);
        end
    endtask

    // Output in cycle cc reflects the counter of cycle cc-1; counter is 0 in cycle st.
    function automatic logic [1:0] exp_bits(input int n, input int st, input int cc);
        int k;
        if (n == 0 || cc - 1 < st) return 2'b00;
        k = (cc - 1 - st) % n;
        return {k == n - 1, k < (n + 1) / 2};
    endfunction

    task automatic check_outs();
        logic [3:0] ce_x;
        logic [3:0] clk_x;
        logic [1:0] b;
        for (int i = 0; i < 4; i++) begin
            b        = exp_bits(n_e[i], st_e[i], c);
            ce_x[i]  = b[1];
            clk_x[i] = b[0];
        end
        check("ce_out", 32'(ce_out), 32'(ce_x));
        check("clk_out", 32'(clk_out), 32'(clk_x));
        check("locked", 32'(locked), 32'(lock_e));
    endtask

    task automatic step();
        @(negedge clk);
        c++;
        check_outs();
    endtask

    task automatic run_to(input int last);
        while (c < last) step();
    endtask

    task automatic set_defaults();
        n_e[0] = 1; n_e[1] = 2; n_e[2] = 3; n_e[3] = 4;
        for (int i = 0; i < 4; i++) st_e[i] = 0;
        lock_e = 1'b1;
        c = 0;
    endtask

    // Release reset and expect locked exactly on the 16th edge afterwards.
    task automatic do_lock();
        @(negedge clk);
        areset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                check("lock_early", 32'(locked), 32'd0);
                check("lock_ce0", 32'(ce_out), 32'd0);
            end
            if (k == 16) check("lock_rise", 32'(locked), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ce", 32'(ce_out), 32'd0);
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);

        do_lock();
        set_defaults();
        check_outs();
        while (c < 25) begin
            step();
            if (c == 12) check("ce_align12", 32'(ce_out), 32'hF);
        end

        // ch3 -> 6 while its counter is 1
        cfg_ch = 4'd3; cfg_div = 8'd6; cfg_valid = 1'b1;
        #1 check("ready_ch3_pre", 32'(cfg_ready), 32'd1);
        step(); cfg_valid = 1'b0;
        #1 check("ready_ch3_pend", 32'(cfg_ready), 32'd0);
        step();
        check("ready_ch3_pend2", 32'(cfg_ready), 32'd0);
        step();
        check("ready_ch3_back", 32'(cfg_ready), 32'd1);
        n_e[3] = 6; st_e[3] = 28;
        run_to(40);

        // ch1 disable at end of period, then re-enable with 5
        cfg_ch = 4'd1; cfg_div = 8'd0; cfg_valid = 1'b1;
        step(); cfg_valid = 1'b0;
        #1 check("ready_ch1_pend", 32'(cfg_ready), 32'd0);
        step();
        check("ready_ch1_back", 32'(cfg_ready), 32'd1);
        n_e[1] = 0;
        run_to(44);
        cfg_ch = 4'd1; cfg_div = 8'd5; cfg_valid = 1'b1;
        #1 check("ready_ch1_dis", 32'(cfg_ready), 32'd1);
        n_e[1] = 5; st_e[1] = 45;
        step(); cfg_valid = 1'b0;
        run_to(60);

        // out-of-range channel write is accepted and dropped
        cfg_ch = 4'd9; cfg_div = 8'd7; cfg_valid = 1'b1;
        #1 check("ready_ch9", 32'(cfg_ready), 32'd1);
        step(); cfg_valid = 1'b0;
        run_to(70);

        // sync_req realigns everything after a fresh 16-cycle lock
        sync_req = 1'b1;
        lock_e = 1'b0;
        for (int i = 0; i < 4; i++) st_e[i] = 87;
        step(); sync_req = 1'b0;
        run_to(86);
        lock_e = 1'b1;
        run_to(100);

        // pending write on ch3 is lost when reset hits mid-period
        cfg_ch = 4'd3; cfg_div = 8'd2; cfg_valid = 1'b1;
        step(); cfg_valid = 1'b0;
        #1 check("ready_ch3_pend3", 32'(cfg_ready), 32'd0);
        areset = 1'b1;
        #1;
        check("mid_rst_ce", 32'(ce_out), 32'd0);
        check("mid_rst_clk", 32'(clk_out), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        do_lock();
        set_defaults();
        check_outs();
        run_to(16);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
